// File: rtl/reg_bank_byte_writer.sv
// rtl/reg_bank_byte_writer.sv - write side of the 8088 register bank (16 x 16-bit array)
//
// Purpose: holds the 16 x 16-bit register array that feeds the bank's read mux,
// and accepts writes from the 8-bit external data path. Byte writes go straight
// to the low or high half. Word writes take two beats: the low byte is staged
// and both bytes are committed together when the high byte arrives.
//
// Optional feature: define REG_BANK_WRLOCK_EN to add the wr_lock input. A commit
// to a locked register is accepted, suppressed, and answered with err.
//
// Ports:
//   clk       in   1    clock, all state on rising edge
//   rst       in   1    synchronous reset, active-high
//   wr_valid  in   1    write beat offered
//   wr_ready  out  1    beat accepted when wr_valid & wr_ready at rising edge
//   wr_addr   in   4    target register index
//   wr_mode   in   2    00 low byte, 01 high byte, 10 word (two beats), 11 reserved
//   wr_data   in   8    byte data
//   wr_lock   in   16   per-register write lock (REG_BANK_WRLOCK_EN only)
//   regs      out  256  register array; register i = regs[16*i+15:16*i]
//   busy      out  1    low byte of a word write is staged
//   done      out  1    one-cycle pulse, commit took effect
//   err       out  1    one-cycle pulse, beat or transaction rejected
module reg_bank_byte_writer #(
    parameter logic [15:0] RESET_VAL = 16'h0000,
    parameter int          TIMEOUT   = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [3:0]   wr_addr,
    input  logic [1:0]   wr_mode,
    input  logic [7:0]   wr_data,
`ifdef REG_BANK_WRLOCK_EN
    input  logic [15:0]  wr_lock,
`endif
    output logic [255:0] regs,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_LOW_HELD = 1'b1
    } state_t;

    // Counter value on which one more idle cycle expires the word write.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_regs [16];
    logic [7:0]  r_stage;
    logic [3:0]  r_addr;
    logic [7:0]  r_cnt;
    logic        r_ready;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_locked;
    logic        w_cmt_lo;
    logic        w_cmt_hi;
    logic        w_cmt_word;
    logic        w_commit;
    logic        w_stage_ld;
    logic        w_reject;
    logic [7:0]  w_cnt_nxt;

    assign w_accept = wr_valid & r_ready;

    // Lock is looked up with the beat's own address; a word commit only
    // happens when that address matches the latched one, so it is the target.
`ifdef REG_BANK_WRLOCK_EN
    assign w_locked = wr_lock[wr_addr];
`else
    assign w_locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmt_lo    = 1'b0;
        w_cmt_hi    = 1'b0;
        w_cmt_word  = 1'b0;
        w_stage_ld  = 1'b0;
        w_reject    = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = 8'd0;
                    case (wr_mode)
                        2'b00: begin
                            w_cmt_lo = ~w_locked;
                            w_reject = w_locked;
                        end
                        2'b01: begin
                            w_cmt_hi = ~w_locked;
                            w_reject = w_locked;
                        end
                        2'b10: begin
                            // Low beat is staged regardless of lock.
                            w_stage_ld  = 1'b1;
                            w_state_nxt = S_LOW_HELD;
                        end
                        default: begin
                            w_reject = 1'b1;
                        end
                    endcase
                end
            end
            S_LOW_HELD: begin
                if (w_accept) begin
                    // High beat: wr_mode is ignored, only the address matters.
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                    if (wr_addr == r_addr) begin
                        w_cmt_word = ~w_locked;
                        w_reject   = w_locked;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_reject    = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_commit = w_cmt_lo | w_cmt_hi | w_cmt_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= 8'd0;
            r_addr  <= 4'd0;
            r_cnt   <= 8'd0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            r_cnt   <= w_cnt_nxt;
            // One recovery slot after each commit; rejects leave ready high.
            r_ready <= ~w_commit;
            r_done  <= w_commit;
            r_err   <= w_reject;
            if (w_stage_ld) begin
                r_stage <= wr_data;
                r_addr  <= wr_addr;
            end else if (w_state_nxt == S_IDLE) begin
                r_stage <= 8'd0;
            end
            if (w_cmt_lo) begin
                r_regs[wr_addr][7:0] <= wr_data;
            end
            if (w_cmt_hi) begin
                r_regs[wr_addr][15:8] <= wr_data;
            end
            if (w_cmt_word) begin
                r_regs[wr_addr] <= {wr_data, r_stage};
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_regs_out
            assign regs[16*g +: 16] = r_regs[g];
        end
    endgenerate

    assign wr_ready = r_ready;
    assign busy     = (r_state == S_LOW_HELD);
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_reg_bank_byte_writer.sv
// tb/tb_reg_bank_byte_writer.sv - directed vector bench for reg_bank_byte_writer
module tb_reg_bank_byte_writer;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [1:0]   wr_mode;
    logic [7:0]   wr_data;
`ifdef REG_BANK_WRLOCK_EN
    logic [15:0]  wr_lock;
`endif
    logic [255:0] regs;
    logic         busy;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    reg_bank_byte_writer #(
        .RESET_VAL (16'hA5A5),
        .TIMEOUT   (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_mode  (wr_mode),
        .wr_data  (wr_data),
`ifdef REG_BANK_WRLOCK_EN
        .wr_lock  (wr_lock),
`endif
        .regs     (regs),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  a;
        logic [1:0]  m;
        logic [7:0]  d;
        logic        e_ready;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        int          ri;
        logic [15:0] rv;
    } vec_t;

    vec_t        vecs [17];
    logic [15:0] exp_regs [16];

    function automatic logic [15:0] reg_of(input int i);
        return regs[16*i +: 16];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic e_ready, input logic e_busy,
                             input logic e_done, input logic e_err);
        chk({name, ".ready"}, {15'd0, wr_ready}, {15'd0, e_ready});
        chk({name, ".busy"},  {15'd0, busy},     {15'd0, e_busy});
        chk({name, ".done"},  {15'd0, done},     {15'd0, e_done});
        chk({name, ".err"},   {15'd0, err},      {15'd0, e_err});
    endtask

    // Inputs change at the falling edge, outputs are read at the next falling edge.
    task automatic step(input logic v, input logic [3:0] a, input logic [1:0] m, input logic [7:0] d);
        wr_valid = v;
        wr_addr  = a;
        wr_mode  = m;
        wr_data  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string name);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s.reg%0d", name, i), reg_of(i), exp_regs[i]);
        end
    endtask

    initial begin
        //          v     a      m      d       rdy   bsy   done  err   ri  rv
        vecs[0]  = '{1'b1, 4'd3,  2'b00, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 3,  16'hA534};
        vecs[1]  = '{1'b1, 4'd3,  2'b01, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 3,  16'hA534};
        vecs[2]  = '{1'b1, 4'd3,  2'b01, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 3,  16'h1234};
        vecs[3]  = '{1'b0, 4'd0,  2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3,  16'h1234};
        vecs[4]  = '{1'b1, 4'd15, 2'b10, 8'hCD, 1'b1, 1'b1, 1'b0, 1'b0, 15, 16'hA5A5};
        vecs[5]  = '{1'b0, 4'd15, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 15, 16'hA5A5};
        vecs[6]  = '{1'b0, 4'd15, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 15, 16'hA5A5};
        vecs[7]  = '{1'b0, 4'd15, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 15, 16'hA5A5};
        vecs[8]  = '{1'b1, 4'd15, 2'b00, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 15, 16'hABCD};
        vecs[9]  = '{1'b0, 4'd0,  2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 15, 16'hABCD};
        vecs[10] = '{1'b1, 4'd2,  2'b10, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 2,  16'hA5A5};
        vecs[11] = '{1'b1, 4'd4,  2'b01, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 4,  16'hA5A5};
        vecs[12] = '{1'b0, 4'd0,  2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2,  16'hA5A5};
        vecs[13] = '{1'b1, 4'd5,  2'b11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 5,  16'hA5A5};
        vecs[14] = '{1'b0, 4'd0,  2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5,  16'hA5A5};
        vecs[15] = '{1'b1, 4'd0,  2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0,  16'h00A5};
        vecs[16] = '{1'b0, 4'd0,  2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0,  16'h00A5};

        for (int i = 0; i < 16; i++) exp_regs[i] = 16'hA5A5;

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 4'd0;
        wr_mode  = 2'b00;
        wr_data  = 8'h00;
`ifdef REG_BANK_WRLOCK_EN
        wr_lock  = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("reset");

        for (int k = 0; k < 17; k++) begin
            step(vecs[k].v, vecs[k].a, vecs[k].m, vecs[k].d);
            chk_flags($sformatf("vec%0d", k), vecs[k].e_ready, vecs[k].e_busy,
                      vecs[k].e_done, vecs[k].e_err);
            chk($sformatf("vec%0d.reg%0d", k, vecs[k].ri), reg_of(vecs[k].ri), vecs[k].rv);
        end
        exp_regs[3]  = 16'h1234;
        exp_regs[15] = 16'hABCD;
        exp_regs[0]  = 16'h00A5;
        chk_all("table");

        // Timeout: low beat to reg 7 then silence; expiry on the 15th idle edge.
        step(1'b1, 4'd7, 2'b10, 8'h77);
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 4'd0, 2'b00, 8'h00);
            chk_flags($sformatf("to_wait%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 4'd0, 2'b00, 8'h00);
        chk_flags("to_expire", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("to_expire.reg7", reg_of(7), 16'hA5A5);
        step(1'b0, 4'd0, 2'b00, 8'h00);
        chk_flags("to_after", 1'b1, 1'b0, 1'b0, 1'b0);

        // High beat on the last allowed idle edge still commits.
        step(1'b1, 4'd8, 2'b10, 8'h01);
        repeat (14) step(1'b0, 4'd0, 2'b00, 8'h00);
        chk("late.busy", {15'd0, busy}, 16'd1);
        chk("late.reg8_staged", reg_of(8), 16'hA5A5);
        step(1'b1, 4'd8, 2'b11, 8'h02);
        chk_flags("late_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("late_commit.reg8", reg_of(8), 16'h0201);
        exp_regs[8] = 16'h0201;
        step(1'b0, 4'd0, 2'b00, 8'h00);

`ifdef REG_BANK_WRLOCK_EN
        wr_lock = 16'h0001;
        step(1'b1, 4'd0, 2'b10, 8'hEF);
        chk_flags("lock0_low", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd0, 2'b10, 8'hBE);
        chk_flags("lock0_high", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lock0.reg0", reg_of(0), 16'h00A5);
        step(1'b1, 4'd1, 2'b10, 8'hEF);
        chk_flags("lock1_low", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd1, 2'b10, 8'hBE);
        chk_flags("lock1_high", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lock1.reg1", reg_of(1), 16'hBEEF);
        exp_regs[1] = 16'hBEEF;
        step(1'b0, 4'd0, 2'b00, 8'h00);
        wr_lock = 16'h0000;
`endif

        chk_all("pre_reset");

        // Reset mid-word, with a competing byte beat on the reset edge.
        step(1'b1, 4'd9, 2'b10, 8'h99);
        chk("mid.busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        step(1'b1, 4'd1, 2'b00, 8'h5A);
        rst = 1'b0;
        chk_flags("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'hA5A5;
        chk_all("mid_reset");
        // A lone high beat to reg 9 must not pick up the discarded staged byte.
        step(1'b1, 4'd9, 2'b01, 8'h42);
        chk_flags("post_reset", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_reset.reg9", reg_of(9), 16'h42A5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
